// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for the parametrised FIFO
// Purpose: count-width helper and the status bundle shared by the FIFO, its
//          interface and any monitor that wants all flags as one value.
// Ports:   none (package).
package fifo_pkg;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the pointers.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bus of the parametrised FIFO
// Purpose: groups write/read requests, data and status of sync_fifo_param.
// Ports:   none; master modport = producer/consumer side, slave modport = FIFO side.
//          wr, data_in, rd            : requests and write data (master -> slave)
//          data_out, fifo_cnt, flags  : read data, occupancy, status (slave -> master)
interface sync_fifo_param_if import fifo_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = cnt_w(DEPTH);

    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic [CW-1:0]     fifo_cnt;

    modport master (
        output wr, data_in, rd,
        input  data_out, full, empty, almost_full, almost_empty,
               overflow, underflow, fifo_cnt
    );

    modport slave (
        input  wr, data_in, rd,
        output data_out, full, empty, almost_full, almost_empty,
               overflow, underflow, fifo_cnt
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x DATA_W storage, sync write / async read
// Purpose: FIFO storage array; contents are never reset.
// Ports:   clk   in  clock
//          we    in  write enable
//          waddr in  write address (AW)
//          wdata in  write data (DATA_W)
//          raddr in  read address (AW)
//          rdata out read data, combinational from raddr (DATA_W)
module fifo_mem_2p #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds and FWFT mode
// Purpose: pointers, occupancy count, status flags and read-mode muxing around fifo_mem_2p.
// Ports:   clk  in  clock, all logic on posedge
//          rst  in  synchronous reset, active-high
//          bus  slave modport of sync_fifo_param_if (wr, data_in, rd, data_out,
//               full, empty, almost_full, almost_empty, overflow, underflow, fifo_cnt)
module sync_fifo_param import fifo_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf_q;
    logic              unf_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] head;
    fifo_status_t      status;

    // Level flags come from the registered count only, so rd/wr never reach them combinationally.
    always_comb begin
        status              = '0;
        status.full         = (cnt == CW'(DEPTH));
        status.empty        = (cnt == '0);
        status.almost_full  = (cnt >= CW'(AF_THRESH));
        status.almost_empty = (cnt <= CW'(AE_THRESH));
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    assign wr_acc = bus.wr & ~status.full;
    assign rd_acc = bus.rd & ~status.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.wr & status.full;
            unf_q <= bus.rd & status.empty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A push and pop in the same cycle leave the count unchanged.
            if (wr_acc && !rd_acc) begin
                cnt <= cnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; masked to zero while nothing is stored.
        assign bus.data_out = status.empty ? '0 : head;
    end else begin : g_reg_rd
        logic [DATA_W-1:0] data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= head;
            end
        end

        assign bus.data_out = data_q;
    end

    assign bus.full         = status.full;
    assign bus.empty        = status.empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.overflow     = status.overflow;
    assign bus.underflow    = status.underflow;
    assign bus.fifo_cnt     = cnt;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (registered and FWFT instances)
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if0 ();
    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if1 ();

    assign if0.wr = wr;
    assign if0.rd = rd;
    assign if0.data_in = din;
    assign if1.wr = wr;
    assign if1.rd = rd;
    assign if1.data_in = din;

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference: a queue of stored words plus the last word handed out in registered mode.
    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] exp_dout0;
    logic              exp_ovf;
    logic              exp_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        logic [DATA_W-1:0] head;
        sz   = q.size();
        head = (sz != 0) ? q[0] : '0;
        check_eq({tag, ".cnt"},   32'(if0.fifo_cnt),     32'(sz));
        check_eq({tag, ".full"},  32'(if0.full),         32'(sz == DEPTH));
        check_eq({tag, ".empty"}, 32'(if0.empty),        32'(sz == 0));
        check_eq({tag, ".af"},    32'(if0.almost_full),  32'(sz >= AF));
        check_eq({tag, ".ae"},    32'(if0.almost_empty), 32'(sz <= AE));
        check_eq({tag, ".ovf"},   32'(if0.overflow),     32'(exp_ovf));
        check_eq({tag, ".unf"},   32'(if0.underflow),    32'(exp_unf));
        check_eq({tag, ".dout"},  32'(if0.data_out),     32'(exp_dout0));
        check_eq({tag, ".cnt1"},  32'(if1.fifo_cnt),     32'(sz));
        check_eq({tag, ".dout1"}, 32'(if1.data_out),     32'(head));
    endtask

    task automatic cycle(input logic r, input logic w, input logic rr,
                         input logic [DATA_W-1:0] d, input string tag);
        logic pop_ok;
        logic push_ok;
        rst = r;
        wr  = w;
        rd  = rr;
        din = d;
        if (r) begin
            q.delete();
            exp_dout0 = '0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            exp_ovf = w && (q.size() == DEPTH);
            exp_unf = rr && (q.size() == 0);
            pop_ok  = rr && (q.size() != 0);
            push_ok = w && (q.size() != DEPTH);
            if (pop_ok) exp_dout0 = q.pop_front();
            if (push_ok) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int written;
        int sz;
        logic w;
        logic r;

        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        din = '0;

        // 1. reset
        cycle(1, 0, 0, 8'h00, "rst_a");
        cycle(1, 0, 0, 8'h00, "rst_b");

        // 2. fill 0x01..0x10, then overflow attempt
        for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(i), "fill");
        cycle(0, 1, 0, 8'hFF, "ovf");
        cycle(0, 0, 0, 8'h00, "ovf_gone");

        // 3. drain with registered reads, then underflow attempt
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00, "drain");
        check_eq("drain_last", 32'(if0.data_out), 32'h10);
        cycle(0, 0, 1, 8'h00, "unf");
        cycle(0, 0, 0, 8'h00, "unf_gone");

        // 4. simultaneous rd & wr at cnt=5, 16 and 0
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'h20 + i), "to5");
        cycle(0, 1, 1, 8'h55, "rw5");
        check_eq("rw5_cnt", 32'(if0.fifo_cnt), 32'd5);
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 8'(8'h30 + i), "to16");
        cycle(0, 1, 1, 8'h66, "rw16");
        check_eq("rw16_ovf", 32'(if0.overflow), 32'd1);
        for (int i = 0; i < 15; i++) cycle(0, 0, 1, 8'h00, "to0");
        cycle(0, 1, 1, 8'h77, "rw0");
        check_eq("rw0_unf", 32'(if0.underflow), 32'd1);
        cycle(0, 0, 1, 8'h00, "rw0_rd");
        check_eq("rw0_word", 32'(if0.data_out), 32'h77);

        // 5. random stream with occupancy near 3, then reset at cnt=7
        written = 0;
        for (int k = 0; k < 400 && written < 40; k++) begin
            sz = q.size();
            w  = (sz < 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
            r  = (sz > 3) ? 1'b1 : ((sz == 0) ? 1'b0 : ($urandom_range(0, 1) == 1));
            if (w) written++;
            cycle(0, w, r, 8'($urandom), "rand");
        end
        check_eq("rand_words", 32'(written), 32'd40);
        for (int k = 0; k < DEPTH && q.size() < 7; k++) cycle(0, 1, 0, 8'($urandom), "to7");
        check_eq("pre_rst_cnt", 32'(if0.fifo_cnt), 32'd7);
        cycle(1, 0, 1, 8'h00, "mid_rst");
        cycle(0, 0, 0, 8'h00, "post_rst");

        // 6. first-word-fall-through visibility
        cycle(0, 1, 0, 8'hA5, "fwft_wr");
        check_eq("fwft_dout", 32'(if1.data_out), 32'hA5);
        check_eq("fwft_empty", 32'(if1.empty), 32'd0);
        cycle(0, 0, 1, 8'h00, "fwft_rd");
        check_eq("fwft_dout0", 32'(if1.data_out), 32'h00);
        check_eq("fwft_empty1", 32'(if1.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
